lcd_frame_scan_ctrl: RTL

Frame refresh controller for the 128x64 LCD path. It owns both ports of the 1024x8 display RAM. It scans the frame buffer page by page, emits page/column commands and pixel bytes to the SPI transmitter over a valid/ready handshake, and grants host pixel writes in every cycle the scanner does not need the RAM read port. It sits between the host/image-loader write side, the display RAM and the SPI byte transmitter.

---
 rtl/lcd_frame_scan_ctrl_pkg.sv | 29 ++
 rtl/lcd_frame_scan_ctrl_if.sv | 11 +
 rtl/lcd_frame_scan_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_scan_ctrl_pkg.sv
// Shared definitions for the LCD frame refresh path: FSM state encoding,
// panel command opcodes and default frame geometry.
package lcd_pkg;

  localparam int LCD_ADDR_W    = 10;
  localparam int LCD_PAGES_DEF = 8;
  localparam int LCD_COLS_DEF  = 128;

  localparam logic [7:0] LCD_CMD_PAGE = 8'hB0;
  localparam logic [7:0] LCD_CMD_COLH = 8'h10;
  localparam logic [7:0] LCD_CMD_COLL = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD_PAGE = 3'd1,
    ST_CMD_COLH = 3'd2,
    ST_CMD_COLL = 3'd3,
    ST_RD_ADDR  = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_SEND     = 3'd6,
    ST_DONE     = 3'd7
  } lcd_state_e;

  // Page-address command byte for a given page number.
  function automatic logic [7:0] lcd_page_cmd(input logic [7:0] page);
    return LCD_CMD_PAGE | (page & 8'h0F);
  endfunction

endpackage

// File: rtl/lcd_frame_scan_ctrl_if.sv
// Byte stream towards the SPI transmitter: valid/ready handshake carrying a
// byte plus its data/command flag.
interface lcd_frame_scan_ctrl_if;
  logic       Tx_Valid;
  logic       Tx_DC;
  logic [7:0] Tx_Data;
  logic       Tx_Ready;

  modport master (output Tx_Valid, output Tx_DC, output Tx_Data, input Tx_Ready);
  modport slave  (input Tx_Valid, input Tx_DC, input Tx_Data, output Tx_Ready);
endinterface

// File: rtl/lcd_frame_scan_ctrl.sv
// Frame refresh controller: walks the 1024x8 display RAM page by page, sends
// page/column commands followed by pixel bytes, and gives the RAM write port to
// the host in every cycle except the one where the scanner presents a read.
module lcd_frame_scan_ctrl
  import lcd_pkg::*;
#(
  parameter int PAGES      = LCD_PAGES_DEF,
  parameter int COLS       = LCD_COLS_DEF,
  parameter int COL_OFFSET = 0
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Start_Sig,
  output logic                  Done_Sig,
  output logic                  Busy_Sig,
  input  logic                  Host_Req,
  input  logic [LCD_ADDR_W-1:0] Host_Addr,
  input  logic [7:0]            Host_Data,
  output logic                  Host_Ack,
  output logic                  Write_En_Sig,
  output logic [LCD_ADDR_W-1:0] Write_Addr_Sig,
  output logic [7:0]            Write_Data,
  output logic [LCD_ADDR_W-1:0] Read_Addr_Sig,
  input  logic [7:0]            Read_Data,
  lcd_frame_scan_ctrl_if.master tx
);

  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [PAGE_W-1:0] PAGE_ONE  = PAGE_W'(1);
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);

  // Column commands are constant for the whole frame, set by the panel offset.
  localparam logic [7:0] CMD_COLH_BYTE = LCD_CMD_COLH | 8'((COL_OFFSET >> 4) & 15);
  localparam logic [7:0] CMD_COLL_BYTE = LCD_CMD_COLL | 8'(COL_OFFSET & 15);

  lcd_state_e        r_state;
  lcd_state_e        w_state_nxt;
  logic [PAGE_W-1:0] r_page;
  logic [COL_W-1:0]  r_col;
  logic              r_tx_valid;
  logic              r_tx_dc;
  logic [7:0]        r_tx_data;
  logic              w_tx_hs;
  logic              w_host_ack;
  logic              w_busy;
  logic              w_done;

  assign w_tx_hs = r_tx_valid && tx.Tx_Ready;

  // State register; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: command states and SEND wait for the handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     w_state_nxt = Start_Sig ? ST_CMD_PAGE : ST_IDLE;
      ST_CMD_PAGE: w_state_nxt = w_tx_hs ? ST_CMD_COLH : ST_CMD_PAGE;
      ST_CMD_COLH: w_state_nxt = w_tx_hs ? ST_CMD_COLL : ST_CMD_COLH;
      ST_CMD_COLL: w_state_nxt = w_tx_hs ? ST_RD_ADDR : ST_CMD_COLL;
      ST_RD_ADDR:  w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (!w_tx_hs) begin
          w_state_nxt = ST_SEND;
        end else if (r_col != COL_LAST) begin
          w_state_nxt = ST_RD_ADDR;
        end else if (r_page != PAGE_LAST) begin
          w_state_nxt = ST_CMD_PAGE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: host is only held off while the scanner presents a read address.
  always_comb begin
    w_host_ack = Host_Req && (r_state != ST_RD_ADDR);
    w_busy     = (r_state != ST_IDLE);
    w_done     = (r_state == ST_DONE);
  end

  // Scan position and transmit byte register; the byte is loaded one cycle
  // ahead of the state that owns it so Tx_Valid is up on its first cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_page     <= '0;
      r_col      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_dc    <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start_Sig) begin
            r_page     <= '0;
            r_col      <= '0;
            r_tx_valid <= 1'b1;
            r_tx_dc    <= 1'b0;
            r_tx_data  <= lcd_page_cmd(8'h00);
          end
        end
        ST_CMD_PAGE: begin
          if (w_tx_hs) begin
            r_tx_data <= CMD_COLH_BYTE;
          end
        end
        ST_CMD_COLH: begin
          if (w_tx_hs) begin
            r_tx_data <= CMD_COLL_BYTE;
          end
        end
        ST_CMD_COLL: begin
          if (w_tx_hs) begin
            r_tx_valid <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          r_tx_valid <= 1'b1;
          r_tx_dc    <= 1'b1;
          r_tx_data  <= Read_Data;
        end
        ST_SEND: begin
          if (w_tx_hs) begin
            if (r_col != COL_LAST) begin
              r_col      <= r_col + COL_ONE;
              r_tx_valid <= 1'b0;
            end else if (r_page != PAGE_LAST) begin
              r_col      <= '0;
              r_page     <= r_page + PAGE_ONE;
              r_tx_valid <= 1'b1;
              r_tx_dc    <= 1'b0;
              r_tx_data  <= lcd_page_cmd(8'(r_page) + 8'd1);
            end else begin
              r_tx_valid <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Done_Sig       = w_done;
  assign Busy_Sig       = w_busy;
  assign Host_Ack       = w_host_ack;
  assign Write_En_Sig   = w_host_ack;
  assign Write_Addr_Sig = Host_Addr;
  assign Write_Data     = Host_Data;
  assign Read_Addr_Sig  = LCD_ADDR_W'({r_page, r_col});
  assign tx.Tx_Valid    = r_tx_valid;
  assign tx.Tx_DC       = r_tx_dc;
  assign tx.Tx_Data     = r_tx_data;

endmodule
